// File: rtl/fft_stream_framer_pkg.sv
// Shared FFT package: complex-word layout, field slice constants, mode
// encoding and the log2 helper used to size pointers and column indices.
package fft_stream_framer_pkg;

    // Default complex word width: real half on top, imaginary half below.
    localparam int FFT_DATA_W = 32;
    localparam int CPLX_HALF_W = FFT_DATA_W / 2;

    // Field slice bounds of the default complex word.
    localparam int RE_HI = FFT_DATA_W - 1;
    localparam int RE_LO = FFT_DATA_W / 2;
    localparam int IM_HI = FFT_DATA_W / 2 - 1;
    localparam int IM_LO = 0;

    typedef struct packed {
        logic [CPLX_HALF_W-1:0] re;
        logic [CPLX_HALF_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } fft_mode_e;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int log2c(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_framer_bank.sv
// One POINTS-deep frame buffer: a single natural-order write port and a
// RADIX-lane strided column read (lane k of column c = word c + COLS*k).
module fft_framer_bank
    import fft_stream_framer_pkg::*;
#(
    parameter int RADIX  = 8,
    parameter int POINTS = 64,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                                   clk,
    input  logic                                   we,
    input  logic [log2c(POINTS)-1:0]               waddr,
    input  logic [DATA_W-1:0]                      wdata,
    input  logic [log2c(POINTS/RADIX)-1:0]         rd_col,
    output logic [RADIX*DATA_W-1:0]                rd_data
);

    localparam int COLS  = POINTS / RADIX;
    localparam int PTR_W = log2c(POINTS);

    logic [DATA_W-1:0] mem [0:POINTS-1];

    // Store accepted samples in natural order.
    // NOTE: the storage array has no reset; frame contents are don't-care
    // until the full flag marks them valid, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Combinational strided read: each lane picks one row of the column.
    for (genvar k = 0; k < RADIX; k++) begin : g_lane
        localparam logic [PTR_W-1:0] BASE = PTR_W'(k * COLS);
        assign rd_data[k*DATA_W +: DATA_W] = mem[BASE + PTR_W'(rd_col)];
    end

endmodule

// File: rtl/fft_stream_framer.sv
// Ping-pong input framer for the streaming radix-RADIX 2-D FFT. Collects one
// frame of POINTS samples per bank and presents it column by column.
// Optional feature macro: FFT_FRAMER_IFFT_EN (swap re/im on write when mode=1).
module fft_stream_framer
    import fft_stream_framer_pkg::*;
#(
    parameter int RADIX  = 8,
    parameter int POINTS = 64,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    input  logic                              in_start,
    output logic                              in_ready,
    input  logic                              mode,
    output logic [RADIX*DATA_W-1:0]           out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [log2c(POINTS/RADIX)-1:0]    out_col,
    output logic                              out_last,
    input  logic                              clr_err,
    output logic                              ovf,
    output logic                              frame_err
);

    localparam int COLS  = POINTS / RADIX;
    localparam int PTR_W = log2c(POINTS);
    localparam int COL_W = log2c(COLS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(POINTS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [PTR_W-1:0]          wr_ptr;
    logic                      wr_bank;
    logic                      rd_bank;
    logic [1:0]                full;
    logic [1:0]                full_nxt;
    logic [COL_W-1:0]          rd_col;

    logic                      accept;
    logic                      restart;
    logic                      wr_wrap;
    logic                      xfer;
    logic                      rd_wrap;
    logic                      ovf_evt;
    logic [PTR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [RADIX*DATA_W-1:0]   rd_data0;
    logic [RADIX*DATA_W-1:0]   rd_data1;

    // Handshake and event decode.
    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign ovf_evt   = in_valid && !in_ready;
    // An in_start mid-frame drops the partial frame and restarts at index 0.
    assign restart   = accept && in_start && (wr_ptr != '0);
    assign wr_wrap   = accept && !restart && (wr_ptr == LAST_PTR);
    assign wr_addr   = restart ? '0 : wr_ptr;

    assign out_valid = full[rd_bank];
    assign xfer      = out_valid && out_ready;
    assign rd_wrap   = xfer && (rd_col == LAST_COL);
    assign out_col   = rd_col;
    assign out_last  = out_valid && (rd_col == LAST_COL);
    assign out_data  = rd_bank ? rd_data1 : rd_data0;

`ifdef FFT_FRAMER_IFFT_EN
    // Inverse mode: swap real and imaginary halves so the forward core
    // computes the conjugate-symmetric inverse.
    always_comb begin
        wr_data = in_data;
        if (mode == MODE_INV) begin
            wr_data = {in_data[DATA_W/2-1:0], in_data[DATA_W-1:DATA_W/2]};
        end
    end
`else
    // Forward-only build: mode is kept on the port but has no effect.
    logic unused_mode;
    assign unused_mode = mode;
    assign wr_data     = in_data;
`endif

    // Next full flags: the write side fills wr_bank, the read side frees rd_bank.
    // NOTE: full_nxt gets a complete default before the conditional updates,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_nxt = full;
        if (wr_wrap) full_nxt[wr_bank] = 1'b1;
        if (rd_wrap) full_nxt[rd_bank] = 1'b0;
    end

    // Write pointer and write bank selection.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (restart) begin
                wr_ptr <= PTR_W'(1);
            end else if (wr_ptr == LAST_PTR) begin
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Read column counter and read bank selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_col  <= '0;
            rd_bank <= 1'b0;
        end else if (xfer) begin
            if (rd_col == LAST_COL) begin
                rd_col  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_col <= rd_col + COL_W'(1);
            end
        end
    end

    // Bank full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) full <= 2'b00;
        else     full <= full_nxt;
    end

    // Sticky error flags; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovf       <= (ovf && !clr_err) || ovf_evt;
            frame_err <= (frame_err && !clr_err) || restart;
        end
    end

    fft_framer_bank #(
        .RADIX  (RADIX),
        .POINTS (POINTS),
        .DATA_W (DATA_W)
    ) u_bank0 (
        .clk     (clk),
        .we      (accept && !wr_bank),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data0)
    );

    fft_framer_bank #(
        .RADIX  (RADIX),
        .POINTS (POINTS),
        .DATA_W (DATA_W)
    ) u_bank1 (
        .clk     (clk),
        .we      (accept && wr_bank),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data1)
    );

endmodule

// File: doc/fft_stream_framer.md
# fft_stream_framer

Parametrised input framer for the streaming radix-8 two-dimensional FFT datapath. It accepts one complex sample per cycle, ping-pong buffers one full frame of POINTS samples, and presents that frame column by column as RADIX parallel lanes in the order the first-stage RADIX-point FFT needs. It replaces the fixed 64-point input circuit and input counter pair, and adds back-pressure, frame resynchronisation, error flags and an inverse-FFT mode.

## Interface
- RADIX, 8, lanes per column; power of two, 2..16.
- POINTS, 64, frame length; RADIX*COLS with COLS = POINTS/RADIX, power of two, COLS >= 2.
- DATA_W, 32, complex word: real in [DATA_W-1:DATA_W/2], imaginary in [DATA_W/2-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  sample present.
- in_start  in  1  qualifies in_data as sample 0 of a frame; meaningful only with in_valid.
- in_ready  out  1  framer can accept a sample this cycle.
- mode  in  1  0 = forward, 1 = inverse; sampled per accepted sample.
- out_data  out  RADIX*DATA_W  lane k at [(k+1)*DATA_W-1 : k*DATA_W].
- out_valid  out  1  column available.
- out_ready  in  1  downstream accepts the column.
- out_col  out  log2(COLS)  current column index.
- out_last  out  1  current column is COLS-1.
- clr_err  in  1  synchronous clear of the sticky flags.
- ovf  out  1  sticky: in_valid seen while in_ready = 0.
- frame_err  out  1  sticky: in_start arrived mid-frame.

## Operation
- Two banks of POINTS words, wr_bank and rd_bank pointers, and full[1:0] flags.
- Write: a sample is accepted when in_valid && in_ready. It is stored at wr_ptr in natural order, and wr_ptr increments. On wr_ptr = POINTS-1 the framer sets full[wr_bank], toggles wr_bank and sets wr_ptr to 0.
- in_ready = !full[wr_bank].
- in_start is checked on an accepted sample. If wr_ptr != 0, the partial frame is discarded, frame_err is set, and the sample is written at index 0 with wr_ptr = 1. If wr_ptr = 0, nothing special happens. Samples without in_start are never rejected; alignment comes from the pointer.
- Read: out_valid = full[rd_bank]. Lane k of column c = bank[c + COLS*k].
- A transfer is out_valid && out_ready. Each transfer increments rd_col. On a transfer with rd_col = COLS-1, the framer clears full[rd_bank], toggles rd_bank and sets rd_col to 0.
- ovf is set on in_valid && !in_ready; that sample is dropped.
- clr_err clears both flags. If clr_err coincides with a new error in the same cycle, set wins.
- Reset: pointers, full flags, ovf, frame_err, out_col and out_valid are all 0, and out_last = 0. Bank contents are don't-care.

## Timing
- Last sample accepted in cycle t: out_valid is high in cycle t+1, and out_data is valid in the same cycle from a combinational read of the registered banks.
- A bank freed by the last column transfer in cycle t: in_ready rises in cycle t+1 if that bank was blocking.
- Write and read of different banks in the same cycle are always legal. The same bank can never be both written and read.
- Steady streaming at one sample per cycle: in_ready never drops when out_ready is held high, because COLS <= POINTS.
- out_data, out_col and out_last hold stable while out_valid && !out_ready.
- Reset asserted mid-frame aborts both banks immediately; the first sample after release is index 0.

## Configuration
- FFT_FRAMER_IFFT_EN defined: when mode = 1 at acceptance, the real and imaginary halves are swapped on write. The inverse transform is realised by the same forward core plus an output-side swap.
- Not defined: mode is ignored, data is written unswapped, and the port remains for interface stability.

## Structure
- The shared FFT package holds the DATA_W default, a complex-word typedef, the re/im field slice constants, and the log2 helper.
- One sub-module, fft_framer_bank: a single POINTS-deep register bank with a write port and a RADIX-lane strided column read.
- The framer instantiates two of these plus the pointer and flag control.

## Test plan
- Defaults, samples 0..63 streamed continuously with out_ready = 1 -> column 0 lanes = 0,8,..,56 in cycle 65; column 7 lanes = 7,15,..,63 with out_last = 1; no ovf.
- Three back-to-back frames with out_ready = 0 -> in_ready falls after sample 127; sample 128 offered -> ovf = 1; clr_err -> ovf = 0.
- in_start with sample 20 of a frame -> frame_err = 1; the following 64 samples form the frame, and column 0 lane 0 = the restarted sample.
- Macro defined, mode = 1, sample 0x00050003 -> stored and output as 0x00030005; macro undefined -> 0x00050003.
- Column 3 presented, out_ready toggled 1-0-1 -> out_col advances only on transfer cycles and out_data stays stable while stalled.
- rst pulsed after 40 samples and 2 columns -> out_valid = 0 and in_ready = 1 next cycle; a fresh frame outputs correctly.
